// File: rtl/fsm_seq_driver_if.sv
// ---------------------------------------------------------------------------
// fsm_seq_driver_if
// Bundles the controller handshake and the downstream FSM lines of the
// sequencing driver.
//   start, target   : request from the controller
//   busy, done, err : status back to the controller
//   cur_state       : driver's mirror of the downstream FSM state
//   en, a0..a3      : step enable and condition lines to the downstream FSM
//   y0, y1          : decoded outputs returned by the downstream FSM
// master = the driver itself, slave = the surrounding controller/FSM side.
// ---------------------------------------------------------------------------
interface fsm_seq_driver_if;
   logic       start;
   logic [1:0] target;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] cur_state;
   logic       en;
   logic       a0;
   logic       a1;
   logic       a2;
   logic       a3;
   logic       y0;
   logic       y1;

   modport master (
      input  start, target, y0, y1,
      output busy, done, err, cur_state, en, a0, a1, a2, a3
   );

   modport slave (
      output start, target, y0, y1,
      input  busy, done, err, cur_state, en, a0, a1, a2, a3
   );
endinterface

// File: rtl/fsm_seq_driver.sv
// ---------------------------------------------------------------------------
// fsm_seq_driver
// Walks a 4-state downstream FSM to a requested state one enabled step at a
// time, checking the decoded y0/y1 response after every step.
// Ports:
//   clk  : clock
//   rst  : synchronous active-low reset (shared with the downstream FSM)
//   bus  : fsm_seq_driver_if.master
//            start/target in, busy/done/err/cur_state out,
//            en/a0..a3 out to the FSM, y0/y1 in from the FSM
// Parameters:
//   ANY_MASK : {a3,a2,a1,a0} for S0->S1 and S1->S2 (nonzero)
//   ODD_MASK : {a3,a2,a1,a0} for S2->S3 and S3->S0 (bit1 or bit3 set)
//   SETTLE   : cycles (1..15) from the en pulse to sampling y0/y1
// ---------------------------------------------------------------------------
module fsm_seq_driver #(
   parameter logic [3:0]  ANY_MASK = 4'b0001,
   parameter logic [3:0]  ODD_MASK = 4'b0010,
   parameter int unsigned SETTLE   = 1
) (
   input  logic             clk,
   input  logic             rst,
   fsm_seq_driver_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      PLAN,
      DRIVE,
      WAIT,
      CHECK,
      FIN
   } ctrl_t;

   // WAIT lasts SETTLE-1 cycles; the counter runs 0..SETTLE-2.
   localparam logic [3:0] WAIT_LAST = (SETTLE > 1) ? 4'(SETTLE - 2) : 4'd0;

   ctrl_t      ctrl;
   ctrl_t      ctrl_nxt;
   logic [1:0] cur_state;
   logic [1:0] cur_nxt;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;
   logic       err_q;
   logic       err_nxt;
   logic [1:0] tgt;
   logic [1:0] tgt_nxt;
   logic [1:0] hop;
   logic [1:0] hop_nxt;
   logic [3:0] mask;
   logic [3:0] mask_nxt;
   logic       exp_y0;

   // Control state: reset aborts any request and tracks the downstream reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ctrl      <= IDLE;
         cur_state <= 2'd0;
         cnt       <= 4'd0;
         err_q     <= 1'b0;
      end else begin
         ctrl      <= ctrl_nxt;
         cur_state <= cur_nxt;
         cnt       <= cnt_nxt;
         err_q     <= err_nxt;
      end
   end

   // Request/hop holding registers; only read after being loaded.
   always_ff @(posedge clk) begin
      tgt  <= tgt_nxt;
      hop  <= hop_nxt;
      mask <= mask_nxt;
   end

   always_comb begin
      ctrl_nxt  = ctrl;
      cur_nxt   = cur_state;
      cnt_nxt   = cnt;
      err_nxt   = err_q;
      tgt_nxt   = tgt;
      hop_nxt   = hop;
      mask_nxt  = mask;
      exp_y0    = (cur_state == 2'd3);

      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.err       = 1'b0;
      bus.en        = 1'b0;
      bus.a0        = 1'b0;
      bus.a1        = 1'b0;
      bus.a2        = 1'b0;
      bus.a3        = 1'b0;
      bus.cur_state = cur_state;

      case (ctrl)
         IDLE: begin
            if (bus.start) begin
               tgt_nxt  = bus.target;
               err_nxt  = 1'b0;
               ctrl_nxt = PLAN;
            end
         end

         PLAN: begin
            bus.busy = 1'b1;
            if (cur_state == tgt) begin
               ctrl_nxt = FIN;
            end else begin
               // S0/S1 never see all-zero lines; the zero-line step is
               // only used from S3 as the one-hop route to S2.
               case (cur_state)
                  2'd0: begin
                     hop_nxt  = 2'd1;
                     mask_nxt = ANY_MASK;
                  end
                  2'd1: begin
                     hop_nxt  = 2'd2;
                     mask_nxt = ANY_MASK;
                  end
                  2'd2: begin
                     hop_nxt  = 2'd3;
                     mask_nxt = ODD_MASK;
                  end
                  default: begin
                     if (tgt == 2'd2) begin
                        hop_nxt  = 2'd2;
                        mask_nxt = 4'b0000;
                     end else begin
                        hop_nxt  = 2'd0;
                        mask_nxt = ODD_MASK;
                     end
                  end
               endcase
               ctrl_nxt = DRIVE;
            end
         end

         DRIVE: begin
            bus.busy = 1'b1;
            bus.en   = 1'b1;
            {bus.a3, bus.a2, bus.a1, bus.a0} = mask;
            cur_nxt  = hop;
            cnt_nxt  = 4'd0;
            ctrl_nxt = (SETTLE > 1) ? WAIT : CHECK;
         end

         WAIT: begin
            bus.busy = 1'b1;
            if (cnt == WAIT_LAST) begin
               cnt_nxt  = 4'd0;
               ctrl_nxt = CHECK;
            end else begin
               cnt_nxt  = cnt + 4'd1;
            end
         end

         CHECK: begin
            bus.busy = 1'b1;
            // y0==y1 is caught here too, since exactly one must match.
            if ((bus.y0 != exp_y0) || (bus.y1 != !exp_y0)) begin
               err_nxt  = 1'b1;
               ctrl_nxt = FIN;
            end else if (cur_state == tgt) begin
               ctrl_nxt = FIN;
            end else begin
               ctrl_nxt = PLAN;
            end
         end

         FIN: begin
            bus.done = 1'b1;
            bus.err  = err_q;
            ctrl_nxt = IDLE;
         end

         default: begin
            ctrl_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fsm_seq_driver.sv
// ---------------------------------------------------------------------------
// tb_fsm_seq_driver
// Bench for fsm_seq_driver with a behavioural downstream FSM. u_dut runs with
// SETTLE=1 for the stepping scenarios; u_dut4 runs with SETTLE=4 for the
// mid-request reset scenario.
// ---------------------------------------------------------------------------
module tb_fsm_seq_driver;

   typedef struct {
      logic       err;
      logic [1:0] cur;
      int         lat;
      int         steps;
   } res_t;

   logic clk;
   logic rst;
   logic rst4;
   logic y0_kill;
   logic [1:0] st;
   logic [1:0] st4;

   int checks;
   int failures;

   logic [3:0] pat_q[$];
   res_t       res_q[$];

   fsm_seq_driver_if bus ();
   fsm_seq_driver_if bus4 ();

   fsm_seq_driver #(.ANY_MASK(4'b0001), .ODD_MASK(4'b0010), .SETTLE(1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fsm_seq_driver #(.ANY_MASK(4'b0001), .ODD_MASK(4'b0010), .SETTLE(4)) u_dut4 (
      .clk (clk),
      .rst (rst4),
      .bus (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream FSM: S0-any->S1-any->S2-odd->S3; S3-zero->S2, S3-odd->S0.
   function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic [3:0] a);
      logic [1:0] n;
      n = s;
      case (s)
         2'd0: if (a != 4'd0) n = 2'd1;
         2'd1: if (a != 4'd0) n = 2'd2;
         2'd2: if (a[1] || a[3]) n = 2'd3;
         default: begin
            if (a == 4'd0) n = 2'd2;
            else if (a[1] || a[3]) n = 2'd0;
         end
      endcase
      return n;
   endfunction

   always @(posedge clk) begin
      if (!rst) st <= 2'd0;
      else if (bus.en) st <= fsm_next(st, {bus.a3, bus.a2, bus.a1, bus.a0});
   end

   always @(posedge clk) begin
      if (!rst4) st4 <= 2'd0;
      else if (bus4.en) st4 <= fsm_next(st4, {bus4.a3, bus4.a2, bus4.a1, bus4.a0});
   end

   assign bus.y0  = (st == 2'd3) && !y0_kill;
   assign bus.y1  = (st != 2'd3);
   assign bus4.y0 = (st4 == 2'd3);
   assign bus4.y1 = (st4 != 2'd3);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request on u_dut and follow it to done, popping expected
   // a-line patterns on every en pulse and the expected result on done.
   task automatic run_req(input string name, input logic [1:0] t, input int n,
                          input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2,
                          input logic exp_err, input logic [1:0] exp_cur, input int exp_lat);
      logic [3:0] pats[3];
      res_t       r;
      int         lat;
      int         steps;
      logic       got;
      pats[0] = p0;
      pats[1] = p1;
      pats[2] = p2;
      for (int i = 0; i < n; i++) pat_q.push_back(pats[i]);
      r.err   = exp_err;
      r.cur   = exp_cur;
      r.lat   = exp_lat;
      r.steps = n;
      res_q.push_back(r);

      @(negedge clk);
      bus.start  = 1'b1;
      bus.target = t;
      lat   = 1;
      steps = 0;
      got   = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         lat++;
         if (lat == 2) chk({name, "_busy_rise"}, bus.busy, 1);
         if (bus.en) begin
            steps++;
            if (pat_q.size() == 0) chk({name, "_en_count"}, steps, n);
            else chk({name, "_a_lines"}, {bus.a3, bus.a2, bus.a1, bus.a0}, pat_q.pop_front());
         end
         if (bus.done) got = 1'b1;
      end
      chk({name, "_done_seen"}, got, 1);
      if (got) begin
         r = res_q.pop_front();
         chk({name, "_err"}, bus.err, r.err);
         chk({name, "_cur_state"}, bus.cur_state, r.cur);
         chk({name, "_latency"}, lat, r.lat);
         chk({name, "_steps"}, steps, r.steps);
         chk({name, "_busy_at_done"}, bus.busy, 0);
      end
      chk({name, "_pats_left"}, pat_q.size(), 0);
      pat_q.delete();
      res_q.delete();
      @(negedge clk);
      chk({name, "_done_single"}, bus.done, 0);
   endtask

   initial begin
      int   en_seen;
      int   lat;
      logic done4;
      logic got;
      logic en_after;

      checks     = 0;
      failures   = 0;
      rst        = 1'b0;
      rst4       = 1'b0;
      y0_kill    = 1'b0;
      bus.start  = 1'b0;
      bus.target = 2'd0;
      bus4.start = 1'b0;
      bus4.target = 2'd0;

      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_en", bus.en, 0);
      chk("rst_a_lines", {bus.a3, bus.a2, bus.a1, bus.a0}, 4'b0000);
      chk("rst_cur_state", bus.cur_state, 2'd0);
      rst  = 1'b1;
      rst4 = 1'b1;

      run_req("s0_to_s3", 2'd3, 3, 4'b0001, 4'b0001, 4'b0010, 1'b0, 2'd3, 11);
      chk("s0_to_s3_y0", bus.y0, 1);

      run_req("s3_to_s2", 2'd2, 1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 5);
      chk("s3_to_s2_y1", bus.y1, 1);

      run_req("s2_to_s1", 2'd1, 3, 4'b0010, 4'b0010, 4'b0001, 1'b0, 2'd1, 11);

      run_req("s1_to_s0", 2'd0, 3, 4'b0001, 4'b0010, 4'b0010, 1'b0, 2'd0, 11);

      run_req("zero_step", 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 3);

      y0_kill = 1'b1;
      run_req("y0_fault", 2'd3, 3, 4'b0001, 4'b0001, 4'b0010, 1'b1, 2'd3, 11);
      en_after = 1'b0;
      repeat (4) begin
         @(negedge clk);
         en_after = en_after | bus.en;
      end
      chk("y0_fault_no_more_en", en_after, 0);
      chk("y0_fault_cur_hold", bus.cur_state, 2'd3);
      y0_kill = 1'b0;

      run_req("s3_to_s0", 2'd0, 1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 5);

      // Reset during the WAIT that follows the second en pulse (SETTLE=4).
      @(negedge clk);
      bus4.start  = 1'b1;
      bus4.target = 2'd3;
      en_seen = 0;
      done4   = 1'b0;
      for (int c = 0; c < 100 && en_seen < 2; c++) begin
         @(negedge clk);
         bus4.start = 1'b0;
         if (bus4.en) en_seen++;
         done4 = done4 | bus4.done;
      end
      chk("abort_step2_reached", en_seen, 2);
      @(negedge clk);
      chk("abort_in_wait_busy", bus4.busy, 1);
      chk("abort_in_wait_en", bus4.en, 0);
      rst4 = 1'b0;
      @(negedge clk);
      done4 = done4 | bus4.done;
      chk("abort_busy", bus4.busy, 0);
      chk("abort_en", bus4.en, 0);
      chk("abort_cur_state", bus4.cur_state, 2'd0);
      rst4 = 1'b1;
      repeat (2) begin
         @(negedge clk);
         done4 = done4 | bus4.done;
      end
      chk("abort_no_done", done4, 0);

      bus4.start  = 1'b1;
      bus4.target = 2'd1;
      lat = 1;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk);
         bus4.start = 1'b0;
         lat++;
         if (bus4.en) chk("after_abort_a_lines", {bus4.a3, bus4.a2, bus4.a1, bus4.a0}, 4'b0001);
         if (bus4.done) got = 1'b1;
      end
      chk("after_abort_done_seen", got, 1);
      chk("after_abort_err", bus4.err, 0);
      chk("after_abort_cur_state", bus4.cur_state, 2'd1);
      chk("after_abort_latency", lat, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
